ex_issue_ctrl: RTL and testbench

EX_ISSUE_CTRL -- requirements
Module: ex_issue_ctrl

---
 rtl/ex_issue_ctrl_if.sv | 29 ++
 rtl/ex_issue_ctrl.sv | 119 +++++++++++
 tb/tb_ex_issue_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_issue_ctrl_if.sv
// Issue-control bundle between the register-read latch, the EX stage and writeback.
interface ex_issue_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             valid_in;
    logic             is_multi;
    logic [CNT_W-1:0] iter_cnt;
    logic             flush;
    logic             wb_stall;
    logic             stall_out;
    logic             latch_en;
    logic             ex_valid;
    logic             unit_start;
    logic             unit_busy;
    logic [1:0]       state;
    logic [15:0]      busy_cycles;

    // Stimulus side: drives the op and pipeline conditions.
    modport master (
        output valid_in, is_multi, iter_cnt, flush, wb_stall,
        input  stall_out, latch_en, ex_valid, unit_start, unit_busy, state, busy_cycles
    );

    // Controller side.
    modport slave (
        input  valid_in, is_multi, iter_cnt, flush, wb_stall,
        output stall_out, latch_en, ex_valid, unit_start, unit_busy, state, busy_cycles
    );
endinterface

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: single-cycle ops pass straight through, multi-cycle
// ops start the iterative unit, hold the pipe while it runs, then hand off to WB.
module ex_issue_ctrl #(
    parameter int unsigned CNT_W = 4
) (
    input logic           clk,
    input logic           rst,
    ex_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      busy_q, busy_d;

    logic accept;
    logic stall_out, latch_en, ex_valid, unit_start;

    assign accept = bus.valid_in & ~bus.flush & ~bus.wb_stall;

    // State, iteration counter and RUN-cycle counter; reset acts without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, counter and combinational handshake decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_out  = 1'b0;
        latch_en   = 1'b0;
        ex_valid   = 1'b0;
        unit_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_out = bus.valid_in & bus.wb_stall;
                if (accept) begin
                    if (!bus.is_multi) begin
                        ex_valid = 1'b1;
                        latch_en = 1'b1;
                    end else begin
                        unit_start = 1'b1;
                        if (bus.iter_cnt > CNT_W'(1)) begin
                            cnt_d   = bus.iter_cnt - CNT_W'(1);
                            state_d = StRun;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StRun: begin
                stall_out = 1'b1;
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                stall_out = 1'b1;
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (!bus.wb_stall) begin
                    ex_valid = 1'b1;
                    latch_en = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Keep the handshake quiet while reset is held, whatever the inputs do.
        if (rst) begin
            stall_out  = 1'b0;
            latch_en   = 1'b0;
            ex_valid   = 1'b0;
            unit_start = 1'b0;
        end
    end

    // Saturating count of cycles spent in RUN.
    always_comb begin
        busy_d = busy_q;
        if (state_q == StRun && busy_q != 16'hFFFF) begin
            busy_d = busy_q + 16'd1;
        end
    end

    assign bus.stall_out   = stall_out;
    assign bus.latch_en    = latch_en;
    assign bus.ex_valid    = ex_valid;
    assign bus.unit_start  = unit_start;
    assign bus.unit_busy   = (state_q == StRun) & ~rst;
    assign bus.state       = state_q;
    assign bus.busy_cycles = busy_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Scoreboard bench for ex_issue_ctrl: a timestamp-based reference model predicts
// each cycle's outputs, a negedge monitor compares them against the DUT.
module tb_ex_issue_ctrl;

    logic clk = 1'b0;
    logic rst;

    ex_issue_ctrl_if #(.CNT_W(4)) bus ();

    ex_issue_ctrl #(.CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall_out;
        logic        latch_en;
        logic        ex_valid;
        logic        unit_start;
        logic        unit_busy;
        logic [1:0]  state;
        logic [15:0] busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: an op in flight produces its result at cycle ready_at.
    int          cyc      = 0;
    bit          pending  = 0;
    int          ready_at = 0;
    int unsigned run_seen = 0;
    int          ev_count = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive, predict, push the prediction, advance the model.
    task automatic step(input bit v, input bit m, input int n, input bit f, input bit s);
        exp_t e;
        @(posedge clk);
        #1;
        bus.valid_in = v;
        bus.is_multi = m;
        bus.iter_cnt = 4'(n);
        bus.flush    = f;
        bus.wb_stall = s;
        e = '0;
        e.busy_cycles = 16'(run_seen);
        if (!pending) begin
            e.state     = 2'b00;
            e.stall_out = v & s;
            if (v && !f && !s) begin
                if (!m) begin
                    e.ex_valid = 1'b1;
                    e.latch_en = 1'b1;
                end else begin
                    e.unit_start = 1'b1;
                    pending      = 1;
                    ready_at     = cyc + ((n > 1) ? n : 1);
                end
            end
        end else if (cyc < ready_at) begin
            e.state     = 2'b01;
            e.stall_out = 1'b1;
            e.unit_busy = 1'b1;
            if (run_seen < 65535) run_seen++;
            if (f) pending = 0;
        end else begin
            e.state     = 2'b10;
            e.stall_out = 1'b1;
            if (f) begin
                pending = 0;
            end else if (!s) begin
                e.ex_valid = 1'b1;
                e.latch_en = 1'b1;
                pending    = 0;
            end
        end
        if (e.ex_valid) ev_count++;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_out",   16'(bus.stall_out),  16'(e.stall_out));
            chk("latch_en",    16'(bus.latch_en),   16'(e.latch_en));
            chk("ex_valid",    16'(bus.ex_valid),   16'(e.ex_valid));
            chk("unit_start",  16'(bus.unit_start), 16'(e.unit_start));
            chk("unit_busy",   16'(bus.unit_busy),  16'(e.unit_busy));
            chk("state",       16'(bus.state),      16'(e.state));
            chk("busy_cycles", bus.busy_cycles,     e.busy_cycles);
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"},      16'(bus.state),      16'h0);
        chk({tag, "_busy"},       bus.busy_cycles,     16'h0);
        chk({tag, "_stall_out"},  16'(bus.stall_out),  16'h0);
        chk({tag, "_latch_en"},   16'(bus.latch_en),   16'h0);
        chk({tag, "_ex_valid"},   16'(bus.ex_valid),   16'h0);
        chk({tag, "_unit_start"}, 16'(bus.unit_start), 16'h0);
        chk({tag, "_unit_busy"},  16'(bus.unit_busy),  16'h0);
    endtask

    initial begin
        int ev_before;
        rst          = 1'b1;
        bus.valid_in = 1'b1;
        bus.is_multi = 1'b0;
        bus.iter_cnt = '0;
        bus.flush    = 1'b0;
        bus.wb_stall = 1'b0;
        #2;
        // Reset held with an acceptable single op on the inputs: everything quiet.
        chk_quiet("reset");
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        rst          = 1'b0;

        // Back-to-back single-cycle ops.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        // Multi op, iter_cnt=4, clean handshake.
        step(1, 1, 4, 0, 0);
        idle(5);
        // Same with WB stalled in cycles 4-6.
        step(1, 1, 4, 0, 0);
        idle(3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        idle(2);
        // iter_cnt=6 flushed at cycle 2.
        step(1, 1, 6, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(8);
        // iter_cnt 1 and 0 go straight to DONE.
        step(1, 1, 1, 0, 0);
        idle(2);
        step(1, 1, 0, 0, 0);
        idle(2);
        // Flush in DONE beats the handshake; flush/stall block acceptance in IDLE.
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        step(1, 1, 3, 0, 1);
        step(1, 1, 3, 1, 0);
        // DONE handshake followed immediately by a new accept.
        step(1, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(20);

        // Asynchronous reset pulse mid-RUN.
        step(1, 1, 6, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        #1;
        rst = 1'b0;
        pending  = 0;
        run_seen = 0;
        ev_before = ev_count;
        idle(10);
        @(negedge clk);
        #1;
        chk("no_ev_after_rst", 16'(ev_count - ev_before), 16'h0);
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
